ahb_apb_bridge_fsm: RTL and testbench
=====================================

// Module: ahb_apb_bridge_fsm
// PURPOSE
//  Parametrised AHB-Lite to APB3 bridge controller for NSLV APB slaves.
//  Captures one AHB transfer per address phase, decodes it to a one-hot PSEL,
//  runs the APB SETUP/ACCESS protocol with PREADY wait states and PSLVERR,
//  returns the two-cycle AHB ERROR response, and bounds stalled accesses with a timeout.
// PARAMETERS
//  ADDR_W   32  AHB/APB address width
//  DATA_W   32  AHB/APB data width
//  NSLV     4   number of APB slaves (1..16)
//  DEC_LSB  28  slave index = haddr[DEC_LSB +: SEL_W]; SEL_W = max(1, clog2(NSLV)) (localparam)
//  TIMEOUT  16  max ACCESS cycles without pready before error abort; 0 disables the timeout
// PORTS
//  hclk       in   1            clock
//  hresetn    in   1            async active-low reset
//  hsel       in   1            bridge selected
//  htrans     in   2            AHB transfer type; only NONSEQ(10)/SEQ(11) start a transfer
//  hwrite     in   1            1 = write
//  haddr      in   ADDR_W       address (address phase)
//  hwdata     in   DATA_W       write data (data phase)
//  hready_in  in   1            bus HREADY
//  hreadyout  out  1            transfer done / bridge ready
//  hresp      out  1            0 = OKAY, 1 = ERROR
//  hrdata     out  DATA_W       read data (muxed prdata)
//  paddr      out  ADDR_W       APB address
//  pwdata     out  DATA_W       APB write data
//  pwrite     out  1            APB direction
//  psel       out  NSLV         one-hot slave select
//  penable    out  1            APB enable
//  prdata     in   NSLV*DATA_W  slave read data, slave i at [i*DATA_W +: DATA_W]
//  pready     in   NSLV         per-slave ready
//  pslverr    in   NSLV         per-slave error
// BEHAVIOUR
//  - Accept = hsel & htrans[1] & hready_in, sampled in IDLE, in ACCESS on the completing cycle, or in ERR2.
//    On accept, latch haddr, hwrite and the slave index. BUSY and IDLE htrans are ignored.
//  - States and transitions:
//    IDLE   --accept-->        WWAIT (write), SETUP (read), ERR1 (index >= NSLV; no APB access)
//    WWAIT  --always-->        SETUP; pwdata <= hwdata
//    SETUP  --always-->        ACCESS
//    ACCESS --pready & !err--> IDLE, or next accepted transfer
//    ACCESS --pready & err, or timeout--> ERR1
//    ERR1   --always-->        ERR2
//    ERR2   --always-->        IDLE, or next accepted transfer
//  - APB outputs are registered:
//    - SETUP: psel one-hot[idx]=1, penable=0.
//    - ACCESS: psel held, penable=1.
//    - All other states: psel=0, penable=0.
//    - paddr and pwrite are stable from SETUP through ACCESS.
//  - hreadyout is combinational:
//    1 in IDLE; 1 in ACCESS & pready[idx] & !pslverr[idx]; 1 in ERR2; otherwise 0.
//  - hresp = 1 only in ERR1 and ERR2.
//  - hrdata = prdata[idx] is combinational. It is valid when hreadyout=1 in ACCESS of a read.
//  - Latency with zero APB wait states: read data phase 2 cycles (SETUP, ACCESS);
//    write data phase 3 cycles (WWAIT, SETUP, ACCESS). Each pready=0 cycle adds one.
//  - Timeout: counter clears on entering ACCESS and increments each ACCESS cycle with pready=0.
//    When it reaches TIMEOUT-1 with pready still 0: drop psel/penable next cycle and go to ERR1.
//  - Write data is taken from hwdata only in WWAIT. Later hwdata changes are ignored.
//  - Reset (asynchronous): state=IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0,
//    counter=0, hreadyout=1, hresp=0. A transfer in flight is dropped with no response.
//  - hsize/hburst/hprot are not used: every transfer is full DATA_W.
// STRUCTURE
//  - Package ahb_apb_pkg: state encodings (IDLE..ERR2), HTRANS codes, HRESP codes, clog2 function.
//  - Sub-module apb_slave_mux: combinational selection of prdata/pready/pslverr by slave index.
//  - FSM, address/control latches and timeout counter stay in this module.
// TESTING
//  - Read, NSLV=4, haddr=0x2000_0010, slave 2 pready=1, prdata=0xCAFE_F00D
//    -> psel=0100 for 2 cycles, hreadyout low 1 cycle, then hreadyout=1 with hrdata=0xCAFE_F00D.
//  - Write, haddr=0x1000_0004, hwdata=0xA5A5_0001, slave 1 inserts 3 pready=0 cycles
//    -> pwdata=0xA5A5_0001, penable high 4 cycles, hreadyout low 5 cycles, hresp=0.
//  - Back-to-back write then read, second address phase on the completing cycle
//    -> SETUP of the read in the very next cycle, no IDLE gap.
//  - pslverr=1 on slave 0 at completion -> hresp=1 for 2 cycles, hreadyout 0 then 1;
//    same for haddr=0x5000_0000 with NSLV=4, where psel never asserts.
//  - TIMEOUT=16, pready held 0 -> psel drops after 16 ACCESS cycles, ERROR response follows;
//    with TIMEOUT=0 the access waits indefinitely.
//  - hresetn asserted mid-ACCESS -> psel/penable=0 and hreadyout=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ahb_apb_pkg.sv
// ahb_apb_pkg: state, HTRANS and HRESP encodings plus a constant clog2 for the AHB-to-APB bridge
package ahb_apb_pkg;
  typedef enum logic [2:0] {IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2} state_t;
  typedef enum logic [1:0] {HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_SEQ} htrans_t;
  typedef enum logic {HRESP_OKAY, HRESP_ERROR} hresp_t;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/apb_slave_mux.sv
// apb_slave_mux: selects the addressed slave's read data, ready and error
module apb_slave_mux #(
  parameter int DATA_W = 32,
  parameter int NSLV = 4,
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0]       idx,
  input  logic [NSLV*DATA_W-1:0] prdata,
  input  logic [NSLV-1:0]        pready,
  input  logic [NSLV-1:0]        pslverr,
  output logic [DATA_W-1:0]      rdata,
  output logic                   ready,
  output logic                   slverr
);
  logic hit;
  assign hit = {1'b0, idx} < (SEL_W + 1)'(NSLV);
  assign rdata = hit ? prdata[idx*DATA_W +: DATA_W] : '0;
  assign ready = hit && pready[idx];
  assign slverr = hit && pslverr[idx];
endmodule

// File: rtl/ahb_apb_bridge_fsm.sv
// ahb_apb_bridge_fsm: AHB-Lite to APB3 bridge with one-hot decode, wait states, error response and timeout
module ahb_apb_bridge_fsm
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSLV = 4,
  parameter int DEC_LSB = 28,
  parameter int TIMEOUT = 16
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic                   hsel,
  input  logic [1:0]             htrans,
  input  logic                   hwrite,
  input  logic [ADDR_W-1:0]      haddr,
  input  logic [DATA_W-1:0]      hwdata,
  input  logic                   hready_in,
  output logic                   hreadyout,
  output logic                   hresp,
  output logic [DATA_W-1:0]      hrdata,
  output logic [ADDR_W-1:0]      paddr,
  output logic [DATA_W-1:0]      pwdata,
  output logic                   pwrite,
  output logic [NSLV-1:0]        psel,
  output logic                   penable,
  input  logic [NSLV*DATA_W-1:0] prdata,
  input  logic [NSLV-1:0]        pready,
  input  logic [NSLV-1:0]        pslverr
);
  localparam int SEL_W = NSLV > 1 ? clog2(NSLV) : 1;
  localparam int HI_W = ADDR_W - DEC_LSB;
  localparam int CNT_W = TIMEOUT > 1 ? clog2(TIMEOUT) : 1;
  state_t state, nxt, start;
  logic [SEL_W-1:0] idx, dec_idx, sel_idx;
  logic [HI_W-1:0] hi;
  logic [CNT_W-1:0] cnt;
  logic ready, slverr, bad, done, accept, tmo;
  apb_slave_mux #(.DATA_W(DATA_W), .NSLV(NSLV), .SEL_W(SEL_W)) u_mux (
    .idx(idx), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .rdata(hrdata), .ready(ready), .slverr(slverr)
  );
  assign hi = haddr[ADDR_W-1:DEC_LSB];
  assign dec_idx = hi[SEL_W-1:0];
  assign bad = |(hi >> SEL_W) || {1'b0, dec_idx} >= (SEL_W + 1)'(NSLV);
  assign done = state == ACCESS && ready && !slverr;
  assign accept = hsel && hready_in && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ)
                  && (state == IDLE || state == ERR2 || done);
  assign tmo = TIMEOUT != 0 && !ready && cnt == CNT_W'(TIMEOUT - 1);
  assign start = bad ? ERR1 : hwrite ? WWAIT : SETUP;
  assign sel_idx = accept ? dec_idx : idx;
  assign hreadyout = state == IDLE || state == ERR2 || done;
  assign hresp = state == ERR1 || state == ERR2 ? HRESP_ERROR : HRESP_OKAY;
  always_comb begin
    nxt = state;
    case (state)
      IDLE, ERR2: nxt = accept ? start : IDLE;
      WWAIT: nxt = SETUP;
      SETUP: nxt = ACCESS;
      ACCESS: nxt = accept ? start : done ? IDLE : ready || tmo ? ERR1 : ACCESS;
      ERR1: nxt = ERR2;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state <= IDLE;
      idx <= '0;
      paddr <= '0;
      pwrite <= 1'b0;
      pwdata <= '0;
      psel <= '0;
      penable <= 1'b0;
      cnt <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        idx <= dec_idx;
        paddr <= haddr;
        pwrite <= hwrite;
      end
      if (state == WWAIT) pwdata <= hwdata;
      psel <= nxt inside {SETUP, ACCESS} ? NSLV'(1) << sel_idx : '0;
      penable <= nxt == ACCESS;
      cnt <= state == ACCESS ? cnt + CNT_W'(!ready) : '0;
    end
  end
endmodule

// File: tb/tb_ahb_apb_bridge_fsm.sv
// tb_ahb_apb_bridge_fsm: scoreboard bench for the AHB-to-APB bridge, with a second instance that has the timeout disabled
module tb_ahb_apb_bridge_fsm;
  import ahb_apb_pkg::*;
  typedef struct packed {logic resp; logic [31:0] data;} exp_t;
  logic hclk = 1'b0, hresetn = 1'b1, hsel = 1'b0, hwrite = 1'b0, hready_in;
  logic [1:0] htrans = 2'b00;
  logic [31:0] haddr = '0, hwdata = '0;
  logic [127:0] prdata = {32'h3333_3333, 32'hCAFE_F00D, 32'h1111_1111, 32'h0BAD_0000};
  logic [3:0] pready = '1, pslverr = '0;
  logic hreadyout, hresp, pwrite, penable;
  logic [31:0] hrdata, paddr, pwdata;
  logic [3:0] psel;
  logic hreadyout_0, hresp_0, pwrite_0, penable_0;
  logic [31:0] hrdata_0, paddr_0, pwdata_0;
  logic [3:0] psel_0;
  exp_t sb[$];
  exp_t e;
  int checks = 0, errors = 0;
  assign hready_in = hreadyout;
  always #5 hclk = ~hclk;
  ahb_apb_bridge_fsm #(.TIMEOUT(16)) dut (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .htrans(htrans), .hwrite(hwrite),
    .haddr(haddr), .hwdata(hwdata), .hready_in(hready_in), .hreadyout(hreadyout),
    .hresp(hresp), .hrdata(hrdata), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
    .psel(psel), .penable(penable), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );
  ahb_apb_bridge_fsm #(.TIMEOUT(0)) dut0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .htrans(htrans), .hwrite(hwrite),
    .haddr(haddr), .hwdata(hwdata), .hready_in(hready_in), .hreadyout(hreadyout_0),
    .hresp(hresp_0), .hrdata(hrdata_0), .paddr(paddr_0), .pwdata(pwdata_0), .pwrite(pwrite_0),
    .psel(psel_0), .penable(penable_0), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );
  task automatic step();
    @(posedge hclk);
    #1;
  endtask
  task automatic idle_bus();
    hsel = 1'b0;
    htrans = HTRANS_IDLE;
  endtask
  task automatic addr(input logic w, input logic [31:0] a, input logic [1:0] t);
    hsel = 1'b1;
    htrans = t;
    hwrite = w;
    haddr = a;
  endtask
  task automatic pop();
    if (sb.size() != 0) e = sb.pop_front();
    else e = 'x;
  endtask
  task automatic test_reset();
    #2 hresetn = 1'b0;
    #1;
    checks++; if ({psel, penable, hreadyout, hresp, pwrite} !== 8'h04) begin errors++; $display("FAIL reset_ctrl: got %h expected 04", {psel, penable, hreadyout, hresp, pwrite}); end
    checks++; if ({paddr, pwdata} !== 64'h0) begin errors++; $display("FAIL reset_regs: got %h expected 0", {paddr, pwdata}); end
    step();
    step();
    hresetn = 1'b1;
    step();
  endtask
  task automatic test_busy();
    addr(1'b0, 32'h2000_0000, HTRANS_BUSY);
    step();
    checks++; if ({psel, penable, hreadyout, hresp} !== 7'b0000_010) begin errors++; $display("FAIL busy_ignored: got %b expected 0000010", {psel, penable, hreadyout, hresp}); end
    idle_bus();
    step();
  endtask
  task automatic test_read();
    addr(1'b0, 32'h2000_0010, HTRANS_NONSEQ);
    sb.push_back('{resp: 1'b0, data: 32'hCAFE_F00D});
    #1;
    checks++; if (hreadyout !== 1'b1) begin errors++; $display("FAIL rd_idle_ready: got %b expected 1", hreadyout); end
    step();
    idle_bus();
    #1;
    checks++; if ({psel, penable, hreadyout, hresp, pwrite, paddr} !== {4'b0100, 4'b0000, 32'h2000_0010}) begin errors++; $display("FAIL rd_setup: got %h expected %h", {psel, penable, hreadyout, hresp, pwrite, paddr}, {4'b0100, 4'b0000, 32'h2000_0010}); end
    step();
    checks++; if ({psel, penable, hreadyout} !== 6'b0100_11) begin errors++; $display("FAIL rd_access: got %b expected 010011", {psel, penable, hreadyout}); end
    pop();
    checks++; if ({hresp, hrdata} !== {e.resp, e.data}) begin errors++; $display("FAIL rd_data: got %h expected %h", {hresp, hrdata}, {e.resp, e.data}); end
    step();
    checks++; if ({psel, penable} !== 5'b0) begin errors++; $display("FAIL rd_release: got %b expected 00000", {psel, penable}); end
  endtask
  task automatic test_write_wait();
    int lo = 0, en = 0;
    logic fin = 1'b0;
    addr(1'b1, 32'h1000_0004, HTRANS_NONSEQ);
    sb.push_back('{resp: 1'b0, data: 'x});
    step();
    hwdata = 32'hA5A5_0001;
    idle_bus();
    #1;
    lo += int'(!hreadyout);
    checks++; if ({psel, penable} !== 5'b0) begin errors++; $display("FAIL wr_wwait_idle_apb: got %b expected 00000", {psel, penable}); end
    step();
    hwdata = 32'hDEAD_BEEF;
    pready = 4'b1101;
    #1;
    lo += int'(!hreadyout);
    checks++; if ({psel, penable, pwrite, pwdata} !== {4'b0010, 2'b01, 32'hA5A5_0001}) begin errors++; $display("FAIL wr_setup: got %h expected %h", {psel, penable, pwrite, pwdata}, {4'b0010, 2'b01, 32'hA5A5_0001}); end
    for (int k = 0; k < 20 && !fin; k++) begin
      step();
      pready = k >= 3 ? 4'b1111 : 4'b1101;
      #1;
      en += int'(penable);
      lo += int'(!hreadyout);
      if (hreadyout) begin
        fin = 1'b1;
        pop();
        checks++; if ({hresp, psel, paddr, pwdata} !== {e.resp, 4'b0010, 32'h1000_0004, 32'hA5A5_0001}) begin errors++; $display("FAIL wr_complete: got %h expected %h", {hresp, psel, paddr, pwdata}, {e.resp, 4'b0010, 32'h1000_0004, 32'hA5A5_0001}); end
      end
    end
    checks++; if (fin !== 1'b1) begin errors++; $display("FAIL wr_timeout: got %b expected 1", fin); end
    checks++; if (en !== 4) begin errors++; $display("FAIL wr_penable_cycles: got %0d expected 4", en); end
    checks++; if (lo !== 5) begin errors++; $display("FAIL wr_hready_low_cycles: got %0d expected 5", lo); end
    step();
  endtask
  task automatic test_back_to_back();
    addr(1'b1, 32'h3000_0008, HTRANS_NONSEQ);
    sb.push_back('{resp: 1'b0, data: 'x});
    step();
    hwdata = 32'h1234_5678;
    idle_bus();
    step();
    step();
    pop();
    checks++; if ({hreadyout, hresp, psel, pwdata} !== {1'b1, e.resp, 4'b1000, 32'h1234_5678}) begin errors++; $display("FAIL b2b_wr_done: got %h expected %h", {hreadyout, hresp, psel, pwdata}, {1'b1, e.resp, 4'b1000, 32'h1234_5678}); end
    addr(1'b0, 32'h0000_0020, HTRANS_SEQ);
    sb.push_back('{resp: 1'b0, data: 32'h0BAD_0000});
    step();
    idle_bus();
    #1;
    checks++; if ({psel, penable, hreadyout, pwrite, paddr} !== {4'b0001, 3'b000, 32'h0000_0020}) begin errors++; $display("FAIL b2b_rd_setup: got %h expected %h", {psel, penable, hreadyout, pwrite, paddr}, {4'b0001, 3'b000, 32'h0000_0020}); end
    step();
    pop();
    checks++; if ({hreadyout, hresp, hrdata} !== {1'b1, e.resp, e.data}) begin errors++; $display("FAIL b2b_rd_data: got %h expected %h", {hreadyout, hresp, hrdata}, {1'b1, e.resp, e.data}); end
    step();
  endtask
  task automatic test_slverr();
    addr(1'b0, 32'h0000_0000, HTRANS_NONSEQ);
    pslverr = 4'b0001;
    sb.push_back('{resp: 1'b1, data: 'x});
    step();
    idle_bus();
    step();
    checks++; if ({penable, hreadyout, hresp} !== 3'b100) begin errors++; $display("FAIL err_access: got %b expected 100", {penable, hreadyout, hresp}); end
    step();
    checks++; if ({psel, penable, hreadyout, hresp} !== 7'b0000_001) begin errors++; $display("FAIL err_first: got %b expected 0000001", {psel, penable, hreadyout, hresp}); end
    step();
    pop();
    checks++; if ({hreadyout, hresp} !== {1'b1, e.resp}) begin errors++; $display("FAIL err_second: got %b expected %b", {hreadyout, hresp}, {1'b1, e.resp}); end
    pslverr = '0;
    step();
    checks++; if ({hreadyout, hresp} !== 2'b10) begin errors++; $display("FAIL err_release: got %b expected 10", {hreadyout, hresp}); end
  endtask
  task automatic test_bad_addr();
    addr(1'b0, 32'h5000_0000, HTRANS_NONSEQ);
    sb.push_back('{resp: 1'b1, data: 'x});
    step();
    idle_bus();
    #1;
    checks++; if ({psel, penable, hreadyout, hresp} !== 7'b0000_001) begin errors++; $display("FAIL bad_first: got %b expected 0000001", {psel, penable, hreadyout, hresp}); end
    step();
    pop();
    checks++; if ({psel, hreadyout, hresp} !== {4'b0000, 1'b1, e.resp}) begin errors++; $display("FAIL bad_second: got %b expected %b", {psel, hreadyout, hresp}, {4'b0000, 1'b1, e.resp}); end
    step();
  endtask
  task automatic test_timeout();
    int n = 0;
    pready = 4'b0000;
    addr(1'b0, 32'h1000_0000, HTRANS_NONSEQ);
    sb.push_back('{resp: 1'b1, data: 'x});
    step();
    idle_bus();
    for (int k = 0; k < 40; k++) begin
      step();
      if (!penable) break;
      n++;
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL tmo_access_cycles: got %0d expected 16", n); end
    checks++; if ({psel, hreadyout, hresp} !== 6'b0000_01) begin errors++; $display("FAIL tmo_err_first: got %b expected 000001", {psel, hreadyout, hresp}); end
    step();
    pop();
    checks++; if ({hreadyout, hresp} !== {1'b1, e.resp}) begin errors++; $display("FAIL tmo_err_second: got %b expected %b", {hreadyout, hresp}, {1'b1, e.resp}); end
    repeat (10) step();
    checks++; if ({psel_0, penable_0, hreadyout_0} !== 6'b0010_10) begin errors++; $display("FAIL notmo_waiting: got %b expected 001010", {psel_0, penable_0, hreadyout_0}); end
    pready = '1;
    #1;
    checks++; if ({hreadyout_0, hresp_0, hrdata_0} !== {2'b10, 32'h1111_1111}) begin errors++; $display("FAIL notmo_complete: got %h expected %h", {hreadyout_0, hresp_0, hrdata_0}, {2'b10, 32'h1111_1111}); end
    step();
    checks++; if ({psel_0, penable_0} !== 5'b0) begin errors++; $display("FAIL notmo_release: got %b expected 00000", {psel_0, penable_0}); end
  endtask
  task automatic test_async_reset();
    pready = 4'b0000;
    addr(1'b0, 32'h2000_0000, HTRANS_NONSEQ);
    step();
    idle_bus();
    step();
    checks++; if ({psel, penable, hreadyout} !== 6'b0100_10) begin errors++; $display("FAIL arst_before: got %b expected 010010", {psel, penable, hreadyout}); end
    #2 hresetn = 1'b0;
    #1;
    checks++; if ({psel, penable, hreadyout, hresp, psel_0, penable_0, hreadyout_0} !== 13'b0000_0_1_0_0000_0_1) begin errors++; $display("FAIL arst_immediate: got %b expected 0000010000001", {psel, penable, hreadyout, hresp, psel_0, penable_0, hreadyout_0}); end
    @(negedge hclk);
    hresetn = 1'b1;
    pready = '1;
    step();
    checks++; if ({psel, penable, hreadyout, hresp} !== 7'b0000_010) begin errors++; $display("FAIL arst_after: got %b expected 0000010", {psel, penable, hreadyout, hresp}); end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_busy();
    test_read();
    test_write_wait();
    test_back_to_back();
    test_slverr();
    test_bad_addr();
    test_timeout();
    test_async_reset();
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d expected 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
